// File: rtl/mem_avalon_master_if.sv
// mem_avalon_master_if: Avalon-MM bus bundle between the MEM-stage master and a memory slave.
interface mem_avalon_master_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );
    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mem_avalon_master.sv
// mem_avalon_master: MEM-stage load/store to Avalon-MM master bridge with pipeline stall.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_avalon_master (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          funct3,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    mem_avalon_master_if.master avm,
    output logic [31:0]         oData,
    output logic                stall,
    output logic                done,
    output logic                oMisalign
);
    typedef enum logic [1:0] {IDLE, BUS, WAIT, DONE} state_t;
    state_t      state, nxt;
    logic        req, is_rd, mis, mis_req, accept;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    assign req = MemRead | MemWrite;
`ifdef MISALIGN_TRAP_EN
    assign mis_req = (funct3[1:0] == 2'b01) ? Address[0] : (funct3[1:0] != 2'b00) && (Address[1:0] != 2'b00);
`else
    assign mis_req = 1'b0;
`endif
    assign be = (funct3[1:0] == 2'b00) ? 4'b0001 << Address[1:0] :
                (funct3[1:0] == 2'b01) ? 4'b0011 << {Address[1], 1'b0} : 4'b1111;
    assign wd = (funct3[1:0] == 2'b00) ? {4{WriteData[7:0]}} :
                (funct3[1:0] == 2'b01) ? {2{WriteData[15:0]}} : WriteData;
    // Lane selection uses the offset latched at request time, not the live Address.
    assign ld_b = avm.avm_readdata[{off, 3'b000} +: 8];
    assign ld_h = avm.avm_readdata[{off[1], 4'b0000} +: 16];
    assign ld   = (f3[1:0] == 2'b00) ? {{24{ld_b[7] & ~f3[2]}}, ld_b} :
                  (f3[1:0] == 2'b01) ? {{16{ld_h[15] & ~f3[2]}}, ld_h} : avm.avm_readdata;
    assign accept    = (state == BUS) && !avm.avm_waitrequest;
    assign done      = state == DONE;
    assign oMisalign = done & mis;
    assign stall     = (state == IDLE && req) || state == BUS || state == WAIT;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !req ? IDLE : mis_req ? DONE : BUS;
            BUS:     nxt = avm.avm_waitrequest ? BUS : (is_rd && !avm.avm_readdatavalid) ? WAIT : DONE;
            WAIT:    nxt = avm.avm_readdatavalid ? DONE : WAIT;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= nxt;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            avm.avm_address    <= '0;
            avm.avm_read       <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= '0;
            avm.avm_byteenable <= '0;
            oData              <= '0;
            is_rd              <= 1'b0;
            mis                <= 1'b0;
            f3                 <= '0;
            off                <= '0;
        end else begin
            if (state == IDLE && req) begin
                avm.avm_address    <= {Address[31:2], 2'b00};
                avm.avm_byteenable <= be;
                avm.avm_writedata  <= wd;
                avm.avm_read       <= MemRead & ~mis_req;
                avm.avm_write      <= ~MemRead & ~mis_req;
                is_rd              <= MemRead;
                mis                <= mis_req;
                f3                 <= funct3;
                off                <= Address[1:0];
                if (mis_req) oData <= '0;
            end
            if (accept) begin
                avm.avm_read  <= 1'b0;
                avm.avm_write <= 1'b0;
            end
            if ((accept || state == WAIT) && is_rd && avm.avm_readdatavalid) oData <= ld;
        end
    end
endmodule
